// File: rtl/mem_interface_unit_pkg.sv
// Shared definitions for the multicycle memory interface unit and the control module next to it.
// Holds state encodings, default widths and the word-alignment helper.
package mem_interface_unit_pkg;

  localparam int MIU_N       = 32;
  localparam int MIU_ADDR_W  = 32;
  localparam int MIU_TIMEOUT = 64;

  localparam logic [1:0] MIU_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    MIU_IDLE  = 3'd0,
    MIU_REQ   = 3'd1,
    MIU_RWAIT = 3'd2,
    MIU_DONE  = 3'd3,
    MIU_ERR   = 3'd4
  } miu_state_e;

  function automatic logic miu_misaligned(input logic [1:0] byte_off);
    return (byte_off & MIU_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_interface_unit_timeout_counter.sv
// Access watchdog: counts cycles while an access is outstanding and flags expiry.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module miu_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  // Dropping i_count_en (any state other than REQ/RWAIT) rearms the counter at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_count_en) begin
      r_count <= '0;
    end else if (!o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_count_en && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_interface_unit.sv
// Multicycle memory interface: one CPU request, stall on o_mem_busy until o_mem_done.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_interface_unit
  import mem_interface_unit_pkg::*;
#(
  parameter int N       = MIU_N,
  parameter int ADDR_W  = MIU_ADDR_W,
  parameter int TIMEOUT = MIU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic              i_cpu_ifetch,
  input  logic              i_iord,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_alu_result,
  input  logic [N-1:0]      i_cpu_wdata,
  output logic [N-1:0]      o_instr,
  output logic [N-1:0]      o_mdr,
  output logic              o_mem_busy,
  output logic              o_mem_done,
  output logic              o_mem_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [N-1:0]      o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [N-1:0]      i_mem_rdata,
  output logic [2:0]        o_dbg_state
);

  // Handshake: o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata hold steady until a cycle with
  // i_mem_gnt=1 transfers the request; i_mem_rvalid is honoured only while waiting for read data.

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("mem_interface_unit: TIMEOUT must be at least 2");
  end

  miu_state_e          r_state;
  logic                r_we;
  logic                r_ifetch;
  logic [N-1:0]        r_instr;
  logic [N-1:0]        r_mdr;
  logic                r_mem_done;
  logic                r_mem_err;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-3:0]   r_mem_addr;
  logic [N-1:0]        r_mem_wdata;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_active;
  logic                w_expired;

  assign w_addr   = i_iord ? i_alu_result : i_pc;
  assign w_active = (r_state == MIU_REQ) || (r_state == MIU_RWAIT);

`ifdef MEM_TIMEOUT_EN
  miu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_count_en (w_active),
    .o_expired  (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MIU_IDLE;
      r_we        <= 1'b0;
      r_ifetch    <= 1'b0;
      r_instr     <= '0;
      r_mdr       <= '0;
      r_mem_done  <= 1'b0;
      r_mem_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_done <= 1'b0;
      case (r_state)
        MIU_IDLE: begin
          if (i_cpu_req) begin
            r_we        <= i_cpu_we;
            r_ifetch    <= i_cpu_ifetch;
            r_mem_addr  <= w_addr[ADDR_W-1:2];
            r_mem_wdata <= i_cpu_wdata;
            if (miu_misaligned(w_addr[1:0])) begin
              r_state    <= MIU_ERR;
              r_mem_done <= 1'b1;
              r_mem_err  <= 1'b1;
            end else begin
              r_state   <= MIU_REQ;
              r_mem_req <= 1'b1;
              r_mem_we  <= i_cpu_we;
              r_mem_err <= 1'b0;
            end
          end
        end
        // A store granted on the expiry cycle still completes; a read grant there cannot.
        MIU_REQ: begin
          if (i_mem_gnt && r_we) begin
            r_state    <= MIU_DONE;
            r_mem_done <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
          end else if (w_expired) begin
            r_state    <= MIU_ERR;
            r_mem_done <= 1'b1;
            r_mem_err  <= 1'b1;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
          end else if (i_mem_gnt) begin
            r_state   <= MIU_RWAIT;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        MIU_RWAIT: begin
          if (i_mem_rvalid) begin
            if (r_ifetch) begin
              r_instr <= i_mem_rdata;
            end else begin
              r_mdr <= i_mem_rdata;
            end
            r_state    <= MIU_DONE;
            r_mem_done <= 1'b1;
          end else if (w_expired) begin
            r_state    <= MIU_ERR;
            r_mem_done <= 1'b1;
            r_mem_err  <= 1'b1;
          end
        end
        MIU_DONE: r_state <= MIU_IDLE;
        MIU_ERR:  r_state <= MIU_IDLE;
        default:  r_state <= MIU_IDLE;
      endcase
    end
  end

  assign o_mem_busy  = (r_state != MIU_IDLE);
  assign o_instr     = r_instr;
  assign o_mdr       = r_mdr;
  assign o_mem_done  = r_mem_done;
  assign o_mem_err   = r_mem_err;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed and randomized bench for mem_interface_unit against a cycle-count reference model.
module tb_mem_interface_unit;
  import mem_interface_unit_pkg::*;

  localparam int N    = 32;
  localparam int AW   = 32;
  localparam int TMO  = 8;
  localparam int MAXC = 64;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          i_cpu_req, i_cpu_we, i_cpu_ifetch, i_iord;
  logic [AW-1:0] i_pc, i_alu_result;
  logic [N-1:0]  i_cpu_wdata;
  logic [N-1:0]  o_instr, o_mdr;
  logic          o_mem_busy, o_mem_done, o_mem_err, o_mem_req, o_mem_we;
  logic [AW-3:0] o_mem_addr;
  logic [N-1:0]  o_mem_wdata;
  logic          i_mem_gnt, i_mem_rvalid;
  logic [N-1:0]  i_mem_rdata;
  logic [2:0]    o_dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_interface_unit #(.N(N), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cpu_req    (i_cpu_req),
    .i_cpu_we     (i_cpu_we),
    .i_cpu_ifetch (i_cpu_ifetch),
    .i_iord       (i_iord),
    .i_pc         (i_pc),
    .i_alu_result (i_alu_result),
    .i_cpu_wdata  (i_cpu_wdata),
    .o_instr      (o_instr),
    .o_mdr        (o_mdr),
    .o_mem_busy   (o_mem_busy),
    .o_mem_done   (o_mem_done),
    .o_mem_err    (o_mem_err),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [N-1:0]  exp_instr, exp_mdr;
  logic          exp_err;
  logic [N-1:0]  exp_q[$];

  logic          tr_req   [0:MAXC-1];
  logic          tr_busy  [0:MAXC-1];
  logic          tr_done  [0:MAXC-1];
  logic          tr_err   [0:MAXC-1];
  logic          tr_we    [0:MAXC-1];
  logic [AW-3:0] tr_addr  [0:MAXC-1];
  logic [N-1:0]  tr_wdata [0:MAXC-1];
  logic [N-1:0]  tr_instr [0:MAXC-1];
  logic [N-1:0]  tr_mdr   [0:MAXC-1];
  logic [2:0]    tr_state [0:MAXC-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_cpu_req    = 1'b0;
    i_cpu_we     = 1'b0;
    i_cpu_ifetch = 1'b0;
    i_iord       = 1'b0;
    i_pc         = '0;
    i_alu_result = '0;
    i_cpu_wdata  = '0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
  endtask

  // Cycle 0 presents the request; cycle k (k>=1) is sampled and then driven at its negedge.
  task automatic run_access(input logic we, input logic ifetch, input logic iord,
                            input logic [AW-1:0] pc_v, input logic [AW-1:0] alu_v,
                            input logic [N-1:0] wd, input int g, input int r,
                            input logic [N-1:0] rd, input int ncyc, input int hold_last);
    @(negedge clk);
    i_cpu_req    = 1'b1;
    i_cpu_we     = we;
    i_cpu_ifetch = ifetch;
    i_iord       = iord;
    i_pc         = pc_v;
    i_alu_result = alu_v;
    i_cpu_wdata  = wd;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      tr_req[k]   = o_mem_req;
      tr_busy[k]  = o_mem_busy;
      tr_done[k]  = o_mem_done;
      tr_err[k]   = o_mem_err;
      tr_we[k]    = o_mem_we;
      tr_addr[k]  = o_mem_addr;
      tr_wdata[k] = o_mem_wdata;
      tr_instr[k] = o_mdr === o_mdr ? o_instr : o_instr;
      tr_mdr[k]   = o_mdr;
      tr_state[k] = o_dbg_state;
      i_cpu_req = (k <= hold_last);
      if (k <= hold_last) begin
        i_cpu_we     = 1'($urandom_range(0, 1));
        i_cpu_ifetch = 1'($urandom_range(0, 1));
        i_iord       = 1'($urandom_range(0, 1));
        i_pc         = $urandom;
        i_alu_result = $urandom;
        i_cpu_wdata  = $urandom;
      end
      i_mem_gnt = (k == 1 + g);
      if (!we && k == g + 2 + r) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rd;
      end else if (k <= 1 + g && $urandom_range(0, 1) == 1) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = $urandom;
      end else begin
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = $urandom;
      end
    end
    idle_inputs();
  endtask

  // Reference model: derive the completion cycle and register effects from the access rules.
  task automatic txn(input string nm, input logic we, input logic ifetch, input logic iord,
                     input logic [AW-1:0] pc_v, input logic [AW-1:0] alu_v,
                     input logic [N-1:0] wd, input int g, input int r,
                     input logic [N-1:0] rd, input bit hold);
    logic [AW-1:0] a;
    logic [N-1:0]  e;
    bit mis, tmo;
    int comp, done_c, req_end;
    int n_req = 0, n_busy = 0, n_done = 0, n_err = 0, n_fld = 0;
    a    = iord ? alu_v : pc_v;
    mis  = (a % 4) != 0;
    comp = we ? 1 + g : g + 2 + r;
    tmo  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo = !mis && comp > TMO;
`endif
    if (mis) begin
      done_c = 1;  req_end = 0;
    end else if (tmo) begin
      done_c = TMO + 1;  req_end = (1 + g > TMO) ? TMO : 1 + g;
    end else begin
      done_c = comp + 1;  req_end = 1 + g;
    end
    run_access(we, ifetch, iord, pc_v, alu_v, wd, g, r, rd, done_c + 1, hold ? done_c : 0);
    if (!mis && !tmo && !we) begin
      exp_q.push_back(rd);
      if (ifetch) exp_instr = rd;
      else        exp_mdr   = rd;
    end
    exp_err = mis || tmo;
    for (int k = 1; k <= done_c + 1; k++) begin
      n_req  += int'(tr_req[k]  !== (k <= req_end));
      n_busy += int'(tr_busy[k] !== (k <= done_c));
      n_done += int'(tr_done[k] !== (k == done_c));
      n_err  += int'(tr_err[k]  !== ((k >= done_c) ? exp_err : 1'b0));
      if (k <= req_end) begin
        n_fld += int'(tr_addr[k] !== a[AW-1:2]) + int'(tr_we[k] !== we) + int'(tr_wdata[k] !== wd);
      end
    end
    check($sformatf("%s_req_trace", nm),  64'(n_req),  64'd0);
    check($sformatf("%s_busy_trace", nm), 64'(n_busy), 64'd0);
    check($sformatf("%s_done_trace", nm), 64'(n_done), 64'd0);
    check($sformatf("%s_err_trace", nm),  64'(n_err),  64'd0);
    check($sformatf("%s_req_fields", nm), 64'(n_fld),  64'd0);
    check($sformatf("%s_instr", nm), 64'(tr_instr[done_c]), 64'(exp_instr));
    check($sformatf("%s_mdr", nm),   64'(tr_mdr[done_c]),   64'(exp_mdr));
    check($sformatf("%s_idle", nm),  64'(tr_state[done_c + 1]), 64'(MIU_IDLE));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_dest", nm), 64'(ifetch ? tr_instr[done_c] : tr_mdr[done_c]), 64'(e));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [AW-1:0] pc_v, alu_v;
    int n_bad_done;
    idle_inputs();
    exp_instr = '0;  exp_mdr = '0;  exp_err = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_instr", 64'(o_instr), 64'd0);
    check("rst_mdr",   64'(o_mdr),   64'd0);
    check("rst_busy",  64'(o_mem_busy), 64'd0);
    check("rst_done",  64'(o_mem_done), 64'd0);
    check("rst_err",   64'(o_mem_err),  64'd0);
    check("rst_req",   64'(o_mem_req),  64'd0);
    check("rst_we",    64'(o_mem_we),   64'd0);
    check("rst_addr",  64'(o_mem_addr), 64'd0);
    check("rst_wdata", 64'(o_mem_wdata), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'(MIU_IDLE));
    rst = 1'b0;

    txn("fetch", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0abc, '0, 0, 0, 32'h2008_0005, 1'b0);
    check("fetch_addr", 64'(tr_addr[1]), 64'h10);
    check("fetch_done_c3", 64'(tr_done[3]), 64'd1);
    check("fetch_mdr_kept", 64'(o_mdr), 64'd0);

    txn("load", 1'b0, 1'b0, 1'b1, 32'h0000_0777, 32'h0000_0100, '0, 3, 2, 32'hDEAD_BEEF, 1'b1);
    check("load_mdr", 64'(o_mdr), 64'hDEAD_BEEF);
    check("load_instr_kept", 64'(o_instr), 64'h2008_0005);

    txn("store", 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0008, 32'h1234_5678, 0, 0, '0, 1'b0);
    check("store_we",    64'(tr_we[1]),    64'd1);
    check("store_addr",  64'(tr_addr[1]),  64'h2);
    check("store_wdata", 64'(tr_wdata[1]), 64'h1234_5678);
    check("store_done_c2", 64'(tr_done[2]), 64'd1);
    check("store_instr_kept", 64'(o_instr), 64'h2008_0005);
    check("store_mdr_kept",   64'(o_mdr),   64'hDEAD_BEEF);

    txn("misalign", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0102, '0, 0, 0, 32'h5555_5555, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(o_mem_err), 64'd1);
    txn("err_clear", 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, '0, 1, 1, 32'hCAFE_0001, 1'b0);

    // Reset while waiting for read data; a late rvalid must be dropped.
    @(negedge clk);
    i_cpu_req = 1'b1;  i_cpu_ifetch = 1'b1;  i_pc = 32'h0000_0080;
    @(negedge clk);
    i_cpu_req = 1'b0;  i_mem_gnt = 1'b1;
    @(negedge clk);
    i_mem_gnt = 1'b0;
    check("rwait_reached", 64'(o_dbg_state), 64'(MIU_RWAIT));
    #1 rst = 1'b1;
    #1;
    check("rst_mid_busy",  64'(o_mem_busy), 64'd0);
    check("rst_mid_instr", 64'(o_instr), 64'd0);
    check("rst_mid_state", 64'(o_dbg_state), 64'(MIU_IDLE));
    @(negedge clk);
    rst = 1'b0;
    i_mem_rvalid = 1'b1;  i_mem_rdata = 32'hBAD0_BAD0;
    n_bad_done = 0;
    repeat (3) begin
      @(negedge clk);
      n_bad_done += int'(o_mem_done !== 1'b0);
    end
    i_mem_rvalid = 1'b0;
    check("stray_rvalid_done", 64'(n_bad_done), 64'd0);
    check("stray_rvalid_instr", 64'(o_instr), 64'd0);
    check("stray_rvalid_mdr",   64'(o_mdr),   64'd0);
    exp_instr = '0;  exp_mdr = '0;  exp_err = 1'b0;
    exp_q.delete();

    // Reset while a request is outstanding drops mem_req without waiting for a clock edge.
    @(negedge clk);
    i_cpu_req = 1'b1;  i_iord = 1'b1;  i_alu_result = 32'h0000_0010;
    @(negedge clk);
    i_cpu_req = 1'b0;
    check("req_before_rst", 64'(o_mem_req), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("req_async_drop", 64'(o_mem_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

`ifdef MEM_TIMEOUT_EN
    txn("tmo_req", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0200, '0, 40, 0, 32'h7777_7777, 1'b0);
    i_mem_rvalid = 1'b1;  i_mem_rdata = 32'h1111_2222;
    n_bad_done = 0;
    repeat (2) begin
      @(negedge clk);
      n_bad_done += int'(o_mem_done !== 1'b0);
    end
    i_mem_rvalid = 1'b0;
    check("tmo_late_rvalid_done", 64'(n_bad_done), 64'd0);
    check("tmo_late_rvalid_mdr",  64'(o_mdr), 64'(exp_mdr));
    txn("tmo_rwait", 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, '0, 2, 10, 32'h8888_8888, 1'b0);
`else
    txn("long_wait", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0204, '0, 20, 3, 32'h0BAD_F00D, 1'b1);
`endif

    for (int t = 0; t < 40; t++) begin
      pc_v  = $urandom;
      alu_v = $urandom;
      if ($urandom_range(0, 3) != 0) pc_v[1:0]  = 2'b00;
      if ($urandom_range(0, 3) != 0) alu_v[1:0] = 2'b00;
      txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), pc_v, alu_v, $urandom, int'($urandom_range(0, 4)),
          int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_interface_unit.md
Name: mem_interface_unit

Overview:
- Multicycle memory interface between the control FSM/datapath and a variable-latency word memory.
- Replaces fixed wait states: the control FSM raises one request and stalls on mem_busy until mem_done.
- Selects the address from PC or ALU result (IorD) and registers the returned word into the instruction register (IR) or the memory data register (MDR).
- Sits directly downstream of the control module's IorD/MemWrite/IRWrite outputs.

Parameters:
- N, 32, data width in bits.
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.
- TIMEOUT, 64, cycles before an access aborts (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- cpu_req  input  1  access request; sampled only in IDLE
- cpu_we  input  1  1 = store, 0 = read
- cpu_ifetch  input  1  read destination: 1 = IR, 0 = MDR; ignored on stores
- iord  input  1  address select: 0 = pc, 1 = alu_result
- pc  input  ADDR_W  program counter
- alu_result  input  ADDR_W  data address
- cpu_wdata  input  N  store data (register B)
- instr  output  N  instruction register
- mdr  output  N  memory data register
- mem_busy  output  1  high whenever state is not IDLE
- mem_done  output  1  one-cycle completion pulse
- mem_err  output  1  sticky error flag; cleared at next accepted cpu_req
- mem_req  output  1  memory request, held until granted
- mem_we  output  1  memory write enable, qualified by mem_req
- mem_addr  output  ADDR_W-2  word address
- mem_wdata  output  N  write data
- mem_gnt  input  1  memory accepts request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  N  read data

Behaviour:
- Reset values: all outputs 0 (instr, mdr, mem_addr, mem_wdata all zero); state IDLE.
- States: IDLE, REQ, RWAIT, DONE, ERR.
- IDLE, cpu_req=1: latch addr = iord ? alu_result : pc, we, ifetch and wdata.
  - If addr[1:0] != 0 (misaligned): go to ERR; no memory access is issued.
  - Otherwise: go to REQ.
- REQ: mem_req=1; mem_addr/mem_we/mem_wdata come from latched values and are stable until granted.
  - On mem_gnt with store: go to DONE.
  - On mem_gnt with read: go to RWAIT.
  - Same-cycle gnt is permitted.
- RWAIT: mem_req=0; mem_rvalid is legal no earlier than one cycle after gnt.
  - On mem_rvalid: write mem_rdata to instr (ifetch=1) or mdr (ifetch=0); go to DONE.
  - mem_rvalid outside RWAIT is ignored.
- DONE: mem_done=1 for exactly one cycle; instr/mdr already hold the new value; go to IDLE.
- ERR: mem_done=1 and mem_err=1 for one cycle; go to IDLE; mem_err stays high after that.
- Latency (zero-wait memory):
  - Store: accept at cycle 0; mem_req at cycle 1 (gnt); done at cycle 2.
  - Read: gnt at cycle 1, rvalid at cycle 2, done at cycle 3.
- cpu_req while busy is ignored; no queueing.
- instr and mdr change only on their own read completion; all other accesses preserve them.
- Stores never modify instr or mdr.
- Reset mid-access: immediate return to IDLE; mem_req drops asynchronously; instr/mdr cleared; in-flight rdata discarded.
- mem_busy is combinational from state; all other outputs are registered.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter resets on entry to REQ and counts cycles spent in REQ or RWAIT.
  - Reaching TIMEOUT goes to ERR: mem_req drops, and mem_done and mem_err pulse.
  - A later mem_rvalid from the aborted access is ignored.
- Undefined: no counter; waits indefinitely.

Decomposition:
- Shared package holds:
  - State encodings (MIU_IDLE..MIU_ERR, 3 bits).
  - Word-alignment mask constant.
  - Default N/ADDR_W values, shared with control_module.
- One natural sub-module: miu_timeout_counter, instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Fetch, zero-wait memory: pc=0x0000_0040, iord=0, ifetch=1; gnt at cycle 1, rvalid at cycle 2 with rdata=0x2008_0005 -> mem_addr=0x10, instr=0x2008_0005 and mem_done at cycle 3, mdr unchanged.
- Load, slow memory: alu_result=0x100, iord=1; gnt delayed 3 cycles, rvalid delayed 2 more with rdata=0xDEAD_BEEF -> mem_req held steady, mdr=0xDEAD_BEEF, mem_busy high throughout, exactly one mem_done.
- Store: alu_result=0x8, cpu_wdata=0x1234_5678, cpu_we=1, same-cycle gnt -> mem_we=1, mem_addr=0x2, mem_wdata=0x1234_5678, done at cycle 2, instr/mdr unchanged.
- Misaligned: alu_result=0x102 -> mem_req never asserts; mem_done and mem_err at cycle 1; mem_err stays high until the next cpu_req.
- Reset mid-RWAIT, then stray rvalid -> state IDLE, instr=mdr=0, no mem_done.
- With MEM_TIMEOUT_EN, TIMEOUT=8, gnt never asserted -> mem_err and mem_done 8 cycles after entering REQ; mem_req low after that.
